sub_mem_backend: RTL and testbench
==================================

Name: sub_mem_backend

Overview:
- Storage backend behind the AXI subordinate's channel stage.
- Consumes the addresses and data received on the AW, W and AR channels, and throttles those channels through hold flags.
- Performs single-beat writes and reads on an internal byte-addressed memory.
- Issues B responses and R data/responses to the B and R transmit channels.

Parameters:
- DATA_W, 32, data beat width in bits; multiple of 8.
- ADDR_W, 32, address width in bits.
- MEM_BYTES, 4096, memory size in bytes; multiple of DATA_W/8.

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- aw_data  in  ADDR_W  write address from the AW receive stage.
- aw_new  in  1  one-cycle pulse: aw_data is valid this cycle.
- aw_hold  out  1  AW register occupied; AW receive stage must stall.
- w_data  in  DATA_W  write data from the W receive stage.
- w_new  in  1  one-cycle pulse: w_data is valid this cycle.
- w_hold  out  1  W register occupied.
- ar_data  in  ADDR_W  read address from the AR receive stage.
- ar_new  in  1  one-cycle pulse: ar_data is valid this cycle.
- ar_hold  out  1  AR register occupied.
- b_resp  out  2  write response.
- b_en  out  1  one-cycle request to the B transmit stage.
- b_busy  in  1  B transmit stage still has a transfer in flight.
- r_data  out  DATA_W  read data.
- r_resp  out  2  read response.
- r_en  out  1  one-cycle request to the R transmit stage.
- r_busy  in  1  R transmit stage still has a transfer in flight.
- protocol_err  out  1  one-cycle pulse: a new beat arrived while its register was occupied.

Behaviour:
Reset:
- ARESET forces, immediately (asynchronously): both FSMs to IDLE, all hold/en/protocol_err outputs 0, b_resp=0, r_resp=0, r_data=0.
- Memory array is not cleared.
- Reset mid-operation abandons the transaction: no b_en/r_en, no memory write after reset asserts.

Response codes and address checks:
- OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- addr >= MEM_BYTES -> DECERR.
- Otherwise addr not aligned to DATA_W/8 -> SLVERR.
- Otherwise OKAY.
- Word index = addr >> log2(DATA_W/8). Little-endian: byte at the word base address holds data[7:0].

Write FSM (W_IDLE, W_EXEC, W_RESP):
- In W_IDLE, an AW and a W register each capture independently on the edge where their *_new is sampled. They may arrive in either order or on the same edge.
- aw_hold/w_hold are 1 from the cycle after capture until the FSM returns to W_IDLE.
- When both registers are full, the next edge moves the FSM to W_EXEC.
  - Same-edge arrival goes directly to W_EXEC.
- W_EXEC (one cycle):
  - The edge leaving W_EXEC writes the word only if the response is OKAY; otherwise memory is untouched.
  - The same edge registers b_resp. Next state W_RESP.
- W_RESP:
  - b_en = ~b_busy (combinational from state), so b_en is high for exactly one cycle.
  - Stays in W_RESP while b_busy=1.
  - The edge with b_en=1 goes to W_IDLE and clears both registers; holds read 0 the following cycle.
- Latency: capture edge E; b_en high in cycle E+2 when b_busy=0.

Read FSM (R_IDLE, R_READ, R_RESP), independent of the write FSM:
- ar_new sampled in R_IDLE captures ar_data and moves to R_READ; ar_hold=1 until return to R_IDLE.
- The edge leaving R_READ registers r_data and r_resp.
  - r_data = memory word if OKAY, else 0.
- In R_RESP: r_en = ~r_busy, one cycle, then R_IDLE.
- Latency: r_en in cycle E+2 when r_busy=0.
- r_data/r_resp hold their value until the next read.

Collisions and errors:
- Same-edge write (leaving W_EXEC) and read (leaving R_READ) to the same word: the read returns the old data.
- A *_new while the corresponding register is occupied:
  - the beat is dropped;
  - protocol_err pulses for one cycle the following cycle;
  - the held transaction completes unchanged.
- Simultaneous drops on several channels produce a single protocol_err pulse.

Test Plan:
- Write: aw=0x10 with w=0xDEADBEEF on the same edge, b_busy=0 -> b_en pulse 2 cycles later with b_resp=00. Then ar=0x10 -> r_en 2 cycles later, r_data=0xDEADBEEF, r_resp=00.
- w=0xCAFEF00D presented 3 cycles before aw=0x40 -> w_hold=1 for those 3 cycles, b_en 2 cycles after aw_new; a read of 0x40 returns 0xCAFEF00D.
- Write with b_busy=1 for 5 cycles at W_RESP entry -> b_en stays 0, holds stay 1, b_en fires in the cycle b_busy falls, holds drop the cycle after.
- Error responses:
  - write to 0x1000 -> b_resp=11, memory unchanged;
  - write to 0x12 -> b_resp=10;
  - read of 0x2000 -> r_resp=11, r_data=0.
- 0x20 holds 0x11111111; write 0x22222222 to 0x20 timed so W_EXEC and R_READ coincide -> read returns 0x11111111, the next read returns 0x22222222.
- aw_new pulsed again while aw_hold=1 -> protocol_err pulse, original write completes. ARESET asserted in W_RESP with b_busy=1 -> all outputs 0 at once; after release a fresh write to 0x8 completes with b_resp=00.

Source files
------------

// File: rtl/sub_mem_backend.sv
// -----------------------------------------------------------------------------
// sub_mem_backend
//
// Storage backend for an AXI subordinate. It takes the write address, write data
// and read address beats handed over by the receive stages and completes
// single-beat writes and reads on an internal byte-addressed memory. It then
// requests the B and R transmit stages to send the responses.
//
// Write and read paths are two independent FSMs. Each captured beat sits in a
// register whose occupancy is reported on the matching *_hold output. A beat that
// arrives while its register is occupied is dropped and flagged on protocol_err.
//
// Ports
//   ACLK, ARESET      clock; asynchronous active-high reset
//   aw_data/aw_new    write address and its one-cycle valid pulse
//   aw_hold           AW register occupied
//   w_data/w_new      write data and its one-cycle valid pulse
//   w_hold            W register occupied
//   ar_data/ar_new    read address and its one-cycle valid pulse
//   ar_hold           AR register occupied
//   b_resp, b_en      write response and one-cycle send request
//   b_busy            B transmit stage still has a transfer in flight
//   r_data, r_resp    read data and response, held until the next read
//   r_en              one-cycle send request to the R transmit stage
//   r_busy            R transmit stage still has a transfer in flight
//   protocol_err      one-cycle pulse after one or more beats were dropped
// -----------------------------------------------------------------------------
module sub_mem_backend #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              ACLK,
    input  logic              ARESET,

    input  logic [ADDR_W-1:0] aw_data,
    input  logic              aw_new,
    output logic              aw_hold,

    input  logic [DATA_W-1:0] w_data,
    input  logic              w_new,
    output logic              w_hold,

    input  logic [ADDR_W-1:0] ar_data,
    input  logic              ar_new,
    output logic              ar_hold,

    output logic [1:0]        b_resp,
    output logic              b_en,
    input  logic              b_busy,

    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_en,
    input  logic              r_busy,

    output logic              protocol_err
);

    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int WORDS          = MEM_BYTES / BYTES_PER_WORD;
    localparam int OFF_W          = $clog2(BYTES_PER_WORD);
    localparam int IDX_W          = $clog2(WORDS);

    localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES_PER_WORD - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    // Decode errors take priority over misalignment.
    function automatic logic [1:0] addr_resp(input logic [ADDR_W-1:0] addr);
        if (addr >= MEM_LIMIT) begin
            return RESP_DECERR;
        end else if ((addr & ALIGN_MASK) != '0) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [WORDS];

    wr_state_t         r_wstate;
    logic [ADDR_W-1:0] r_aw_addr;
    logic              r_aw_full;
    logic [DATA_W-1:0] r_w_buf;
    logic              r_w_full;
    logic [1:0]        r_b_resp;

    rd_state_t         r_rstate;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic [1:0]        r_rd_resp;

    logic              r_perr;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0]       w_wr_resp;
    logic [1:0]       w_rd_resp;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_aw_drop;
    logic             w_w_drop;
    logic             w_ar_drop;
    logic             w_aw_full_nxt;
    logic             w_w_full_nxt;
    logic             w_mem_we;

    assign w_wr_resp = addr_resp(r_aw_addr);
    assign w_rd_resp = addr_resp(r_ar_addr);
    assign w_wr_idx  = r_aw_addr[OFF_W +: IDX_W];
    assign w_rd_idx  = r_ar_addr[OFF_W +: IDX_W];

    // A beat is lost whenever its register is already holding one.
    assign w_aw_drop = aw_new & r_aw_full;
    assign w_w_drop  = w_new  & r_w_full;
    assign w_ar_drop = ar_new & (r_rstate != R_IDLE);

    // Occupancy after this edge while idle; both set means the pair is complete.
    assign w_aw_full_nxt = r_aw_full | aw_new;
    assign w_w_full_nxt  = r_w_full  | w_new;

    // Gated by ARESET so a reset coinciding with the exec edge cannot commit.
    assign w_mem_we = (r_wstate == W_EXEC) && (w_wr_resp == RESP_OKAY) && !ARESET;

    // ------------------------------------------------------------------
    // Memory array: not reset; old data is seen by a same-edge read.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= r_w_buf;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_aw_addr <= '0;
            r_aw_full <= 1'b0;
            r_w_buf   <= '0;
            r_w_full  <= 1'b0;
            r_b_resp  <= RESP_OKAY;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (aw_new && !r_aw_full) begin
                        r_aw_addr <= aw_data;
                        r_aw_full <= 1'b1;
                    end
                    if (w_new && !r_w_full) begin
                        r_w_buf  <= w_data;
                        r_w_full <= 1'b1;
                    end
                    if (w_aw_full_nxt && w_w_full_nxt) begin
                        r_wstate <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    r_b_resp <= w_wr_resp;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (!b_busy) begin
                        r_aw_full <= 1'b0;
                        r_w_full  <= 1'b0;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_ar_addr <= '0;
            r_rd_data <= '0;
            r_rd_resp <= RESP_OKAY;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (ar_new) begin
                        r_ar_addr <= ar_data;
                        r_rstate  <= R_READ;
                    end
                end
                R_READ: begin
                    r_rd_resp <= w_rd_resp;
                    r_rd_data <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
                    r_rstate  <= R_RESP;
                end
                R_RESP: begin
                    if (!r_busy) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol error: one pulse regardless of how many channels dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_aw_drop | w_w_drop | w_ar_drop;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign aw_hold      = r_aw_full;
    assign w_hold       = r_w_full;
    assign ar_hold      = (r_rstate != R_IDLE);
    assign b_resp       = r_b_resp;
    assign b_en         = (r_wstate == W_RESP) & ~b_busy;
    assign r_data       = r_rd_data;
    assign r_resp       = r_rd_resp;
    assign r_en         = (r_rstate == R_RESP) & ~r_busy;
    assign protocol_err = r_perr;

endmodule

// File: tb/tb_sub_mem_backend.sv
// Bench for sub_mem_backend. Stimulus pushes the expected B and R responses,
// each with the cycle it must appear in, into queues. A monitor on the falling
// edge pops and compares whenever b_en or r_en is high.
module tb_sub_mem_backend;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 4096;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [ADDR_W-1:0] aw_data;
    logic              aw_new;
    logic              aw_hold;
    logic [DATA_W-1:0] w_data;
    logic              w_new;
    logic              w_hold;
    logic [ADDR_W-1:0] ar_data;
    logic              ar_new;
    logic              ar_hold;
    logic [1:0]        b_resp;
    logic              b_en;
    logic              b_busy;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_en;
    logic              r_busy;
    logic              protocol_err;

    sub_mem_backend #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .aw_data     (aw_data),
        .aw_new      (aw_new),
        .aw_hold     (aw_hold),
        .w_data      (w_data),
        .w_new       (w_new),
        .w_hold      (w_hold),
        .ar_data     (ar_data),
        .ar_new      (ar_new),
        .ar_hold     (ar_hold),
        .b_resp      (b_resp),
        .b_en        (b_en),
        .b_busy      (b_busy),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .r_en        (r_en),
        .r_busy      (r_busy),
        .protocol_err(protocol_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          cyc;
        logic [1:0]  resp;
    } b_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one pop per response request seen.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (b_en) begin
                if (b_q.size() == 0) begin
                    check("b_en_unexpected", 32'd1, 32'd0);
                end else begin
                    b_exp_t e;
                    e = b_q.pop_front();
                    check("b_en_cycle", cyc, e.cyc);
                    check("b_resp", {30'd0, b_resp}, {30'd0, e.resp});
                end
            end
            if (r_en) begin
                if (r_q.size() == 0) begin
                    check("r_en_unexpected", 32'd1, 32'd0);
                end else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    check("r_en_cycle", cyc, e.cyc);
                    check("r_data", r_data, e.data);
                    check("r_resp", {30'd0, r_resp}, {30'd0, e.resp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push_b(input int c, input logic [1:0] resp);
        b_exp_t e;
        e.cyc  = c;
        e.resp = resp;
        b_q.push_back(e);
    endtask

    task automatic push_r(input int c, input logic [31:0] data, input logic [1:0] resp);
        r_exp_t e;
        e.cyc  = c;
        e.data = data;
        e.resp = resp;
        r_q.push_back(e);
    endtask

    // Same-edge AW+W; returns in the cycle the FSM is idle again.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp);
        aw_data = addr;
        w_data  = data;
        aw_new  = 1'b1;
        w_new   = 1'b1;
        push_b(cyc + 2, resp);
        tick();
        aw_new = 1'b0;
        w_new  = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        ar_data = addr;
        ar_new  = 1'b1;
        push_r(cyc + 2, data, resp);
        tick();
        ar_new = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_aw_hold"}, {31'd0, aw_hold}, 32'd0);
        check({tag, "_w_hold"}, {31'd0, w_hold}, 32'd0);
        check({tag, "_ar_hold"}, {31'd0, ar_hold}, 32'd0);
        check({tag, "_b_en"}, {31'd0, b_en}, 32'd0);
        check({tag, "_r_en"}, {31'd0, r_en}, 32'd0);
        check({tag, "_perr"}, {31'd0, protocol_err}, 32'd0);
        check({tag, "_b_resp"}, {30'd0, b_resp}, 32'd0);
        check({tag, "_r_resp"}, {30'd0, r_resp}, 32'd0);
        check({tag, "_r_data"}, r_data, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET  = 1'b1;
        aw_data = '0;
        aw_new  = 1'b0;
        w_data  = '0;
        w_new   = 1'b0;
        ar_data = '0;
        ar_new  = 1'b0;
        b_busy  = 1'b0;
        r_busy  = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        ARESET = 1'b0;
        tick();

        // Basic same-edge write then read back.
        do_write(32'h10, 32'hDEADBEEF, 2'b00);
        do_read(32'h10, 32'hDEADBEEF, 2'b00);

        // W first, AW three cycles later.
        w_data = 32'hCAFEF00D;
        w_new  = 1'b1;
        tick();
        w_new = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w_first_w_hold", {31'd0, w_hold}, 32'd1);
            check("w_first_aw_hold", {31'd0, aw_hold}, 32'd0);
            if (i < 2) tick();
        end
        aw_data = 32'h40;
        aw_new  = 1'b1;
        push_b(cyc + 2, 2'b00);
        tick();
        aw_new = 1'b0;
        tick();
        tick();
        do_read(32'h40, 32'hCAFEF00D, 2'b00);

        // B stage busy for 5 cycles after W_RESP entry.
        b_busy  = 1'b1;
        aw_data = 32'h44;
        w_data  = 32'h00000055;
        aw_new  = 1'b1;
        w_new   = 1'b1;
        push_b(cyc + 7, 2'b00);
        tick();
        aw_new = 1'b0;
        w_new  = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("busy_b_en", {31'd0, b_en}, 32'd0);
            check("busy_aw_hold", {31'd0, aw_hold}, 32'd1);
            check("busy_w_hold", {31'd0, w_hold}, 32'd1);
            tick();
        end
        b_busy = 1'b0;
        #1;
        check("busy_release_b_en", {31'd0, b_en}, 32'd1);
        check("busy_release_aw_hold", {31'd0, aw_hold}, 32'd1);
        tick();
        check("after_busy_aw_hold", {31'd0, aw_hold}, 32'd0);
        check("after_busy_w_hold", {31'd0, w_hold}, 32'd0);
        do_read(32'h44, 32'h00000055, 2'b00);

        // Error responses; the misaligned write must leave word 0x10 intact.
        do_write(32'h1000, 32'h12345678, 2'b11);
        do_write(32'h12, 32'hA5A5A5A5, 2'b10);
        do_read(32'h10, 32'hDEADBEEF, 2'b00);
        do_read(32'h2000, 32'h0, 2'b11);

        // Write and read of the same word on the same edge.
        do_write(32'h20, 32'h11111111, 2'b00);
        aw_data = 32'h20;
        w_data  = 32'h22222222;
        ar_data = 32'h20;
        aw_new  = 1'b1;
        w_new   = 1'b1;
        ar_new  = 1'b1;
        push_b(cyc + 2, 2'b00);
        push_r(cyc + 2, 32'h11111111, 2'b00);
        tick();
        aw_new = 1'b0;
        w_new  = 1'b0;
        ar_new = 1'b0;
        tick();
        tick();
        do_read(32'h20, 32'h22222222, 2'b00);

        // Second AW while the first is held: dropped, single error pulse.
        check("perr_idle", {31'd0, protocol_err}, 32'd0);
        aw_data = 32'h50;
        aw_new  = 1'b1;
        tick();
        check("drop_aw_hold", {31'd0, aw_hold}, 32'd1);
        aw_data = 32'h54;
        tick();
        aw_new = 1'b0;
        check("drop_perr_pulse", {31'd0, protocol_err}, 32'd1);
        tick();
        check("drop_perr_clear", {31'd0, protocol_err}, 32'd0);
        w_data = 32'h00000077;
        w_new  = 1'b1;
        push_b(cyc + 2, 2'b00);
        tick();
        w_new = 1'b0;
        tick();
        tick();
        do_read(32'h50, 32'h00000077, 2'b00);

        // Reset while waiting in W_RESP with the B stage busy.
        b_busy  = 1'b1;
        aw_data = 32'h1004;
        w_data  = 32'h00000099;
        aw_new  = 1'b1;
        w_new   = 1'b1;
        tick();
        aw_new = 1'b0;
        w_new  = 1'b0;
        tick();
        check("pre_reset_b_resp", {30'd0, b_resp}, 32'd3);
        check("pre_reset_aw_hold", {31'd0, aw_hold}, 32'd1);
        #2;
        ARESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        ARESET = 1'b0;
        b_busy = 1'b0;
        tick();
        tick();
        check("post_reset_aw_hold", {31'd0, aw_hold}, 32'd0);
        do_write(32'h8, 32'h0BADCAFE, 2'b00);
        do_read(32'h8, 32'h0BADCAFE, 2'b00);

        // Drain any expected responses still outstanding, bounded.
        for (int i = 0; i < 20; i++) begin
            if (b_q.size() == 0 && r_q.size() == 0) break;
            tick();
        end
        check("b_queue_drained", b_q.size(), 32'd0);
        check("r_queue_drained", r_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
